// File: rtl/avst_rr_arbiter.sv
// ---------------------------------------------------------------------------
// avst_rr_arbiter
//
// Round-robin arbiter merging NUM_IN Avalon-ST requester ports onto a single
// registered Avalon-ST output. The output register is the only pipeline
// stage. An accepted input beat appears on the outputs one cycle later,
// tagged with the index of its source on out_channel_o.
//
// Configuration macro:
//   AVST_ARB_PKT_LOCK_EN  defined   : packet-locked arbitration. Once a
//                                     requester starts a multi-beat packet
//                                     (sop=1, eop=0), only that requester is
//                                     served until its eop beat is accepted.
//                                     The round-robin pointer advances per
//                                     packet.
//                         undefined : per-beat round robin. The pointer
//                                     advances on every accepted beat, and
//                                     sop/eop/empty are passed through
//                                     without interpretation.
//
// Ports:
//   clk            in   1                     clock, rising edge
//   reset_n        in   1                     asynchronous active-low reset
//   in_valid_i     in   NUM_IN                per-requester valid
//   in_ready_o     out  NUM_IN                per-requester ready (one-hot or 0)
//   in_data_i      in   NUM_IN*data_width     requester i in slice i
//   in_sop_i       in   NUM_IN                per-requester start of packet
//   in_eop_i       in   NUM_IN                per-requester end of packet
//   in_empty_i     in   NUM_IN*empty_width    per-requester empty field
//   out_valid_o    out  1                     output beat valid
//   out_ready_i    in   1                     downstream ready
//   out_data_o     out  data_width            granted beat data
//   out_sop_o      out  1                     granted beat sop
//   out_eop_o      out  1                     granted beat eop
//   out_empty_o    out  empty_width           granted beat empty (copied as is)
//   out_channel_o  out  channel_width         source requester index
// ---------------------------------------------------------------------------
module avst_rr_arbiter #(
    parameter int NUM_IN        = 4,
    parameter int data_width    = 32,
    parameter int empty_width   = 2,
    parameter int channel_width = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_IN-1:0]               in_valid_i,
    output logic [NUM_IN-1:0]               in_ready_o,
    input  logic [NUM_IN*data_width-1:0]    in_data_i,
    input  logic [NUM_IN-1:0]               in_sop_i,
    input  logic [NUM_IN-1:0]               in_eop_i,
    input  logic [NUM_IN*empty_width-1:0]   in_empty_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [data_width-1:0]           out_data_o,
    output logic                            out_sop_o,
    output logic                            out_eop_o,
    output logic [empty_width-1:0]          out_empty_o,
    output logic [channel_width-1:0]        out_channel_o
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    // Index of the most recently completed grant; search starts just after it.
    logic [IDX_W-1:0]       last_ptr_q;

    logic                   rr_any;
    logic [IDX_W-1:0]       rr_idx;
    logic                   gnt_any;
    logic [IDX_W-1:0]       gnt_idx;

    logic                   load_p0;
    logic                   xfer_ok_p0;
    logic                   accept_p0;
    logic                   ptr_upd;

    logic [data_width-1:0]  sel_data_p0;
    logic                   sel_sop_p0;
    logic                   sel_eop_p0;
    logic [empty_width-1:0] sel_empty_p0;
    logic                   sel_valid_p0;

    logic                     vld_p1;
    logic [data_width-1:0]    data_p1;
    logic                     sop_p1;
    logic                     eop_p1;
    logic [empty_width-1:0]   empty_p1;
    logic [channel_width-1:0] chan_p1;

`ifdef AVST_ARB_PKT_LOCK_EN
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] lock_idx_q;
    logic [IDX_W-1:0] lock_idx_d;
`endif

    // ---- stage p0: arbitration and input select -------------------------

    // Cyclic search from last_ptr+1. Iterating from the farthest candidate
    // down to the nearest lets the nearest valid requester win without an
    // early exit.
    always_comb begin
        logic [IDX_W:0] cand;
        rr_any = 1'b0;
        rr_idx = '0;
        cand   = '0;
        for (int k = NUM_IN; k >= 1; k--) begin
            cand = {1'b0, last_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_IN)) begin
                cand = cand - (IDX_W+1)'(NUM_IN);
            end
            if (in_valid_i[cand[IDX_W-1:0]]) begin
                rr_any = 1'b1;
                rr_idx = cand[IDX_W-1:0];
            end
        end
    end

    // While locked the grant is pinned to the lock owner even if it has
    // dropped valid, so other requesters wait and the output bubbles.
    always_comb begin
        gnt_any = rr_any;
        gnt_idx = rr_idx;
`ifdef AVST_ARB_PKT_LOCK_EN
        if (state_q == LOCK) begin
            gnt_any = 1'b1;
            gnt_idx = lock_idx_q;
        end
`endif
    end

    // Output register may take a new beat when empty or being drained.
    assign load_p0    = out_ready_i | ~vld_p1;
    assign xfer_ok_p0 = load_p0 & reset_n;

    always_comb begin
        in_ready_o = '0;
        if (gnt_any && xfer_ok_p0) begin
            in_ready_o[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_data_p0  = '0;
        sel_sop_p0   = 1'b0;
        sel_eop_p0   = 1'b0;
        sel_empty_p0 = '0;
        sel_valid_p0 = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                sel_data_p0  = in_data_i[i*data_width +: data_width];
                sel_sop_p0   = in_sop_i[i];
                sel_eop_p0   = in_eop_i[i];
                sel_empty_p0 = in_empty_i[i*empty_width +: empty_width];
                sel_valid_p0 = in_valid_i[i];
            end
        end
    end

    assign accept_p0 = gnt_any & xfer_ok_p0 & sel_valid_p0;

`ifdef AVST_ARB_PKT_LOCK_EN
    // Pointer advances once per packet: on any IDLE beat that does not open
    // a lock (single-beat packets and stray non-sop beats), or on the eop
    // that closes a lock.
    assign ptr_upd = accept_p0 &
                     ((state_q == IDLE) ? ~(sel_sop_p0 & ~sel_eop_p0) : sel_eop_p0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            IDLE: begin
                if (accept_p0 && sel_sop_p0 && !sel_eop_p0) begin
                    state_d    = LOCK;
                    lock_idx_d = gnt_idx;
                end
            end
            LOCK: begin
                // Only the lock owner can be accepted here.
                if (accept_p0 && sel_eop_p0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
`else
    assign ptr_upd = accept_p0;
`endif

    // Reset value NUM_IN-1 makes requester 0 the first in line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_ptr_q <= IDX_W'(NUM_IN - 1);
        end else if (ptr_upd) begin
            last_ptr_q <= gnt_idx;
        end
    end

    // ---- stage p1: output register ---------------------------------------

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
        end else if (load_p0) begin
            vld_p1 <= accept_p0;
        end
    end

    // Payload only changes on an accepted beat, so it holds through stalls.
    always_ff @(posedge clk) begin
        if (accept_p0) begin
            data_p1  <= sel_data_p0;
            sop_p1   <= sel_sop_p0;
            eop_p1   <= sel_eop_p0;
            empty_p1 <= sel_empty_p0;
            chan_p1  <= channel_width'(gnt_idx);
        end
    end

    assign out_valid_o   = vld_p1;
    assign out_data_o    = data_p1;
    assign out_sop_o     = sop_p1;
    assign out_eop_o     = eop_p1;
    assign out_empty_o   = empty_p1;
    assign out_channel_o = chan_p1;

endmodule
